// File: rtl/data_mem_arbiter.sv
// Two-port (CPU/DMA) data-memory arbiter with a fixed 3-cycle IDLE/ACCESS/RESP handshake.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module data_mem_arbiter #(
    parameter int DEPTH = 6,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [DW-1:0] addr0,
    input  logic [DW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          err0,
    output logic          err1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          Control,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [DW-1:0] Address,
    output logic [DW-1:0] Writedata,
    input  logic [DW-1:0] ReadData
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [DW-1:0] DEPTH_W = DW'(DEPTH);

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          we_q, we_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          control_q, control_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [DW-1:0] address_q, address_d;
    logic [DW-1:0] writedata_q, writedata_d;

    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic          grant_one;
    logic          sel_we;
    logic [DW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_in_range;
    logic          lat_in_range;
    logic [DW-1:0] resp_rdata;

`ifdef DMEM_ARB_RR_EN
    // prio_q names the port that wins the next tie
    logic prio_q, prio_d;
    assign grant_one = req1 & (~req0 | prio_q);
`else
    assign grant_one = req1 & ~req0;
`endif

    assign sel_we       = grant_one ? we1 : we0;
    assign sel_addr     = grant_one ? addr1 : addr0;
    assign sel_wdata    = grant_one ? wdata1 : wdata0;
    assign sel_in_range = sel_addr < DEPTH_W;
    assign lat_in_range = addr_q < DEPTH_W;
    assign resp_rdata   = (lat_in_range && !we_q) ? ReadData : '0;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        control_d   = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        address_d   = '0;
        writedata_d = '0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        rdata0_d    = '0;
        rdata1_d    = '0;
`ifdef DMEM_ARB_RR_EN
        prio_d      = prio_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d     = ACCESS;
                    gnt_d       = grant_one;
                    we_d        = sel_we;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    // Memory-side outputs are registered, so they are loaded on entry to ACCESS
                    control_d   = sel_in_range;
                    mem_read_d  = sel_in_range & ~sel_we;
                    mem_write_d = sel_in_range & sel_we;
                    address_d   = sel_addr;
                    writedata_d = sel_wdata;
`ifdef DMEM_ARB_RR_EN
                    prio_d      = ~grant_one;
`endif
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (gnt_q) begin
                    ack1_d   = 1'b1;
                    err1_d   = ~lat_in_range;
                    rdata1_d = resp_rdata;
                end else begin
                    ack0_d   = 1'b1;
                    err0_d   = ~lat_in_range;
                    rdata0_d = resp_rdata;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            control_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            address_q   <= '0;
            writedata_q <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
`ifdef DMEM_ARB_RR_EN
            prio_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            control_q   <= control_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
`ifdef DMEM_ARB_RR_EN
            prio_q      <= prio_d;
`endif
        end
    end

    assign Control   = control_q;
    assign MemRead   = mem_read_q;
    assign MemWrite  = mem_write_q;
    assign Address   = address_q;
    assign Writedata = writedata_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed table, corner sequences and random traffic
// against a word-array reference memory. Honours DMEM_ARB_RR_EN for the arbitration expectations.
module tb_data_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        Control, MemRead, MemWrite;
    logic [31:0] Address, Writedata, ReadData;

    logic [31:0] mem [0:7];
    logic        mem_init;
    logic [31:0] ref_mem [0:5];
    int          last_gnt;
    int          vectors;
    int          miscompares;

    data_mem_arbiter #(.DEPTH(6), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .Control(Control), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Writedata(Writedata), .ReadData(ReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory: combinational read, write on the clock edge while MemWrite is high
    always_comb ReadData = (Address < 32'd6) ? mem[Address[2:0]] : 32'd0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= 32'(i);
        end else if (MemWrite && Address < 32'd6) begin
            mem[Address[2:0]] <= Writedata;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int p, input bit r, input bit we, input logic [31:0] a,
                                 input logic [31:0] d);
        if (p == 0) begin
            req0 = r; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    // Called at the falling edge of an IDLE cycle with the request already driven;
    // returns at the falling edge of the following IDLE cycle.
    task automatic expectGrant(input int p, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input bit exp_err, input bit release_req);
        bit inr;
        inr = (addr < 32'd6);
        @(negedge clk);
        checkOutput("access_Control", 32'(Control), 32'(inr));
        checkOutput("access_MemRead", 32'(MemRead), 32'(inr && !we));
        checkOutput("access_MemWrite", 32'(MemWrite), 32'(inr && we));
        if (inr) checkOutput("access_Address", Address, addr);
        if (inr && we) checkOutput("access_Writedata", Writedata, wdata);
        checkOutput("access_acks", 32'({ack1, ack0}), 32'd0);
        @(negedge clk);
        checkOutput("resp_acks", 32'({ack1, ack0}), (p == 0) ? 32'd1 : 32'd2);
        checkOutput("resp_errs", 32'({err1, err0}), exp_err ? ((p == 0) ? 32'd1 : 32'd2) : 32'd0);
        checkOutput("resp_rdata0", rdata0, (p == 0) ? exp_rdata : 32'd0);
        checkOutput("resp_rdata1", rdata1, (p == 1) ? exp_rdata : 32'd0);
        checkOutput("resp_Control", 32'({Control, MemRead, MemWrite}), 32'd0);
        if (we && inr) ref_mem[addr[2:0]] = wdata;
        last_gnt = p;
        if (release_req) applyStimulus(p, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("idle_acks", 32'({ack1, ack0}), 32'd0);
    endtask

    function automatic logic [31:0] modelRead(input bit we, input logic [31:0] addr);
        if (we || addr >= 32'd6) return 32'd0;
        return ref_mem[addr[2:0]];
    endfunction

    function automatic int tieWinner();
`ifdef DMEM_ARB_RR_EN
        return (last_gnt == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    typedef struct {
        int          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t table_v [11];

    initial begin
        vectors     = 0;
        miscompares = 0;
        last_gnt    = 1;
        for (int i = 0; i < 6; i++) ref_mem[i] = 32'(i);

        table_v[0]  = '{0, 1'b0, 32'd3,          32'd0,          32'd3,          1'b0};
        table_v[1]  = '{1, 1'b1, 32'd2,          32'hA5A5A5A5,   32'd0,          1'b0};
        table_v[2]  = '{1, 1'b0, 32'd2,          32'd0,          32'hA5A5A5A5,   1'b0};
        table_v[3]  = '{0, 1'b0, 32'd6,          32'd0,          32'd0,          1'b1};
        table_v[4]  = '{1, 1'b0, 32'hFFFFFFFF,   32'd0,          32'd0,          1'b1};
        table_v[5]  = '{0, 1'b1, 32'd7,          32'hDEADBEEF,   32'd0,          1'b1};
        table_v[6]  = '{0, 1'b0, 32'd5,          32'd0,          32'd5,          1'b0};
        table_v[7]  = '{1, 1'b1, 32'd5,          32'h12345678,   32'd0,          1'b0};
        table_v[8]  = '{0, 1'b0, 32'd5,          32'd0,          32'h12345678,   1'b0};
        table_v[9]  = '{1, 1'b0, 32'd0,          32'd0,          32'd0,          1'b0};
        table_v[10] = '{0, 1'b0, 32'h80000000,   32'd0,          32'd0,          1'b1};

        reset    = 1'b1;
        mem_init = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("reset_acks", 32'({ack1, ack0}), 32'd0);
        checkOutput("reset_errs", 32'({err1, err0}), 32'd0);
        checkOutput("reset_rdata0", rdata0, 32'd0);
        checkOutput("reset_rdata1", rdata1, 32'd0);
        checkOutput("reset_ctrl", 32'({Control, MemRead, MemWrite}), 32'd0);
        checkOutput("reset_Address", Address, 32'd0);
        checkOutput("reset_Writedata", Writedata, 32'd0);
        mem_init = 1'b0;
        reset    = 1'b0;
        @(negedge clk);

        // Both ports held high across four back-to-back transactions
        applyStimulus(0, 1'b1, 1'b0, 32'd1, 32'd0);
        applyStimulus(1, 1'b1, 1'b0, 32'd4, 32'd0);
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
            int w = k % 2;
`else
            int w = 0;
`endif
            expectGrant(w, 1'b0, (w == 0) ? 32'd1 : 32'd4, 32'd0,
                        (w == 0) ? 32'd1 : 32'd4, 1'b0, 1'b0);
        end
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(table_v[i].port, 1'b1, table_v[i].we, table_v[i].addr, table_v[i].wdata);
            expectGrant(table_v[i].port, table_v[i].we, table_v[i].addr, table_v[i].wdata,
                        table_v[i].exp_rdata, table_v[i].exp_err, 1'b1);
        end

        // Reset while a port-1 write is in ACCESS: the write lands, but no ack follows
        applyStimulus(1, 1'b1, 1'b1, 32'd2, 32'hCAFEF00D);
        @(negedge clk);
        checkOutput("rst_access_MemWrite", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("rst_acks", 32'({ack1, ack0}), 32'd0);
        checkOutput("rst_err1", 32'(err1), 32'd0);
        checkOutput("rst_rdata1", rdata1, 32'd0);
        checkOutput("rst_ctrl", 32'({Control, MemRead, MemWrite}), 32'd0);
        checkOutput("rst_Address", Address, 32'd0);
        reset    = 1'b0;
        last_gnt = 1;
        ref_mem[2] = 32'hCAFEF00D;
        applyStimulus(0, 1'b1, 1'b0, 32'd2, 32'd0);
        expectGrant(0, 1'b0, 32'd2, 32'd0, 32'hCAFEF00D, 1'b0, 1'b1);

        // Random traffic: single requests and simultaneous pairs
        for (int n = 0; n < 40; n++) begin
            int          pa, w, l;
            bit          wea, web;
            logic [31:0] aa, ab, da, db;
            pa  = int'($urandom_range(0, 1));
            wea = 1'($urandom_range(0, 1));
            web = 1'($urandom_range(0, 1));
            aa  = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h80000000) : 32'($urandom_range(0, 7));
            ab  = 32'($urandom_range(0, 7));
            da  = $urandom;
            db  = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(0, 1'b1, wea, aa, da);
                applyStimulus(1, 1'b1, web, ab, db);
                w = tieWinner();
                l = 1 - w;
                expectGrant(w, (w == 0) ? wea : web, (w == 0) ? aa : ab, (w == 0) ? da : db,
                            modelRead((w == 0) ? wea : web, (w == 0) ? aa : ab),
                            ((w == 0) ? aa : ab) >= 32'd6, 1'b1);
                expectGrant(l, (l == 0) ? wea : web, (l == 0) ? aa : ab, (l == 0) ? da : db,
                            modelRead((l == 0) ? wea : web, (l == 0) ? aa : ab),
                            ((l == 0) ? aa : ab) >= 32'd6, 1'b1);
            end else begin
                applyStimulus(pa, 1'b1, wea, aa, da);
                expectGrant(pa, wea, aa, da, modelRead(wea, aa), aa >= 32'd6, 1'b1);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
